// File: rtl/ffa_pkg.sv
// Shared types and default widths for the flip-flop-array initiator and its users.
package ffa_pkg;

  localparam int FFA_DATA_W = 8;
  localparam int FFA_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } ffa_init_state_e;

  typedef struct packed {
    logic                  wr;
    logic [FFA_ADDR_W-1:0] addr;
    logic [FFA_DATA_W-1:0] data;
  } ffa_req_t;

  typedef struct packed {
    logic                  wr;
    logic [FFA_ADDR_W-1:0] addr;
    logic [FFA_DATA_W-1:0] data;
    logic                  error;
  } ffa_rsp_t;

endpackage

// File: rtl/ffa_initiator_if.sv
// Request/response channels between a host (master) and the array initiator (slave).
interface ffa_initiator_if
  import ffa_pkg::*;
#(
  parameter int DATA_W = FFA_DATA_W,
  parameter int ADDR_W = FFA_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_wr;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_error;

  modport master (
    output req_valid, req_wr, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_wr, rsp_addr, rsp_data, rsp_error
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_wr, rsp_addr, rsp_data, rsp_error
  );

endinterface

// File: rtl/ffa_initiator.sv
// Single-outstanding initiator: turns one host request into a one-cycle wr/rd strobe
// on the flip-flop array and returns the captured result with a saturating error count.
module ffa_initiator
  import ffa_pkg::*;
#(
  parameter int DATA_W = FFA_DATA_W,
  parameter int ADDR_W = FFA_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  ffa_initiator_if.slave    bus,
  output logic              ffa_wr,
  output logic              ffa_rd,
  output logic [ADDR_W-1:0] ffa_addr,
  output logic [DATA_W-1:0] ffa_din,
  input  logic [DATA_W-1:0] ffa_dout,
  input  logic              ffa_error,
  output logic [CNT_W-1:0]  err_cnt
);

  ffa_init_state_e state;

  // NOTE: every register here is state, so all updates are non-blocking; the async
  // reset branch drops any in-flight request and parks the strobes low at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_wr    <= 1'b0;
      bus.rsp_addr  <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_error <= 1'b0;
      ffa_wr        <= 1'b0;
      ffa_rd        <= 1'b0;
      ffa_addr      <= '0;
      ffa_din       <= '0;
      err_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            ffa_addr      <= bus.req_addr;
            ffa_din       <= bus.req_data;
            bus.rsp_wr    <= bus.req_wr;
            bus.rsp_addr  <= bus.req_addr;
            ffa_wr        <= bus.req_wr;
            ffa_rd        <= ~bus.req_wr;
            bus.req_ready <= 1'b0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          ffa_wr <= 1'b0;
          ffa_rd <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          // Array outputs still hold this op's result; they clear at this same edge.
          bus.rsp_error <= ffa_error;
          bus.rsp_data  <= (bus.rsp_wr | ffa_error) ? '0 : ffa_dout;
          bus.rsp_valid <= 1'b1;
          if (ffa_error && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ffa_initiator.sv
// Directed bench: two initiators (16-bit and 2-bit error counters) run in lockstep,
// each against its own behavioural flip-flop array.
module tb_ffa_initiator;
  import ffa_pkg::*;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  ffa_initiator_if bus ();
  ffa_initiator_if bus_sat ();

  logic       ffa_wr    [2];
  logic       ffa_rd    [2];
  logic [2:0] ffa_addr  [2];
  logic [7:0] ffa_din   [2];
  logic [7:0] ffa_dout  [2];
  logic       ffa_error [2];
  logic [7:0] mem       [2][8];
  logic [7:0] vld       [2];
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt_sat;

  ffa_initiator dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .ffa_wr(ffa_wr[0]), .ffa_rd(ffa_rd[0]), .ffa_addr(ffa_addr[0]), .ffa_din(ffa_din[0]),
    .ffa_dout(ffa_dout[0]), .ffa_error(ffa_error[0]), .err_cnt(err_cnt)
  );

  ffa_initiator #(.CNT_W(2)) dut_sat (
    .clk(clk), .resetn(resetn), .bus(bus_sat),
    .ffa_wr(ffa_wr[1]), .ffa_rd(ffa_rd[1]), .ffa_addr(ffa_addr[1]), .ffa_din(ffa_din[1]),
    .ffa_dout(ffa_dout[1]), .ffa_error(ffa_error[1]), .err_cnt(err_cnt_sat)
  );

  assign bus_sat.req_valid = bus.req_valid;
  assign bus_sat.req_wr    = bus.req_wr;
  assign bus_sat.req_addr  = bus.req_addr;
  assign bus_sat.req_data  = bus.req_data;
  assign bus_sat.rsp_ready = bus.rsp_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: unwritten reads flag error with stale dout; idle strobes clear error.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        vld[i]       <= '0;
        ffa_dout[i]  <= '0;
        ffa_error[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ffa_wr[i]) begin
          mem[i][ffa_addr[i]] <= ffa_din[i];
          vld[i][ffa_addr[i]] <= 1'b1;
          ffa_error[i]        <= 1'b0;
        end else if (ffa_rd[i]) begin
          if (vld[i][ffa_addr[i]]) begin
            ffa_dout[i]  <= mem[i][ffa_addr[i]];
            ffa_error[i] <= 1'b0;
          end else begin
            ffa_error[i] <= 1'b1;
          end
        end else begin
          ffa_error[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ffa_wr[0] & ffa_rd[0]) begin
      errors++;
      $display("FAIL strobe_mutex at %0t: ffa_wr and ffa_rd both 1", $time);
    end
  end

  task automatic do_txn(input ffa_req_t req, input bit consume, output ffa_rsp_t rsp,
                        output int lat);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_timeout: req_ready=%b required 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_wr    = req.wr;
    bus.req_addr  = req.addr;
    bus.req_data  = req.data;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rsp = {bus.rsp_wr, bus.rsp_addr, bus.rsp_data, bus.rsp_error};
    if (consume) begin
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic apply_reset();
    resetn        = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.req_wr   = 1'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    apply_reset();
    checks++;
    if ({bus.req_ready, bus.rsp_valid, ffa_wr[0], ffa_rd[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/wr/rd=%b required 1000",
               {bus.req_ready, bus.rsp_valid, ffa_wr[0], ffa_rd[0]});
    end
    checks++;
    if ({err_cnt, bus.rsp_data, bus.rsp_error} !== 25'd0) begin
      errors++;
      $display("FAIL reset_data: err_cnt=%0d rsp_data=%h rsp_error=%b required all 0",
               err_cnt, bus.rsp_data, bus.rsp_error);
    end
  endtask

  task automatic test_unwritten_read();
    ffa_rsp_t rsp;
    int lat;
    for (int k = 1; k <= 2; k++) begin
      do_txn('{wr: 1'b0, addr: 3'd6, data: 8'h00}, 1'b1, rsp, lat);
      checks++;
      if (rsp !== ffa_rsp_t'({1'b0, 3'd6, 8'h00, 1'b1})) begin
        errors++;
        $display("FAIL unwritten_rsp %0d: got %h required %h", k, rsp,
                 ffa_rsp_t'({1'b0, 3'd6, 8'h00, 1'b1}));
      end
      checks++;
      if (err_cnt !== 16'(k)) begin
        errors++;
        $display("FAIL unwritten_err_cnt %0d: got %0d required %0d", k, err_cnt, k);
      end
    end
  endtask

  task automatic test_write_read();
    ffa_rsp_t rsp;
    int lat;
    do_txn('{wr: 1'b1, addr: 3'd3, data: 8'hA5}, 1'b1, rsp, lat);
    checks++;
    if (rsp !== ffa_rsp_t'({1'b1, 3'd3, 8'h00, 1'b0})) begin
      errors++;
      $display("FAIL write_rsp: got %h required %h", rsp, ffa_rsp_t'({1'b1, 3'd3, 8'h00, 1'b0}));
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL write_latency: got %0d required 3", lat);
    end
    do_txn('{wr: 1'b0, addr: 3'd3, data: 8'hFF}, 1'b1, rsp, lat);
    checks++;
    if (rsp !== ffa_rsp_t'({1'b0, 3'd3, 8'hA5, 1'b0})) begin
      errors++;
      $display("FAIL read_rsp: got %h required %h", rsp, ffa_rsp_t'({1'b0, 3'd3, 8'hA5, 1'b0}));
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL read_latency: got %0d required 3", lat);
    end
  endtask

  task automatic test_all_addresses();
    ffa_rsp_t rsp;
    int lat;
    for (int a = 0; a < 8; a++) begin
      do_txn('{wr: 1'b1, addr: 3'(a), data: 8'(8'h10 + a)}, 1'b1, rsp, lat);
    end
    for (int a = 7; a >= 0; a--) begin
      do_txn('{wr: 1'b0, addr: 3'(a), data: 8'h00}, 1'b1, rsp, lat);
      checks++;
      if ({rsp.data, rsp.error} !== {8'(8'h10 + a), 1'b0}) begin
        errors++;
        $display("FAIL sweep_read addr %0d: data=%h error=%b required data=%h error=0",
                 a, rsp.data, rsp.error, 8'(8'h10 + a));
      end
    end
  endtask

  task automatic test_backpressure();
    ffa_rsp_t rsp;
    int lat;
    do_txn('{wr: 1'b0, addr: 3'd3, data: 8'h00}, 1'b0, rsp, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_wr, bus.rsp_addr, bus.rsp_data, bus.rsp_error}
          !== {1'b1, 1'b0, 1'b0, 3'd3, 8'h13, 1'b0}) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: valid=%b ready=%b data=%h addr=%0d",
                 c, bus.rsp_valid, bus.req_ready, bus.rsp_data, bus.rsp_addr);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: valid/ready=%b required 01",
               {bus.rsp_valid, bus.req_ready});
    end
  endtask

  task automatic test_back_to_back();
    int n_acc, first, second;
    n_acc = 0; first = -1; second = -1;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 3'd3;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 16 && n_acc < 2; c++) begin
      if (bus.req_ready) begin
        if (n_acc == 0) first = c;
        else second = c;
        n_acc++;
      end
      @(posedge clk); #1;
      if (n_acc == 2) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (first !== 0 || second !== 4) begin
      errors++;
      $display("FAIL b2b_spacing: accepts at %0d,%0d required 0,4", first, second);
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_drain: valid/ready=%b required 01", {bus.rsp_valid, bus.req_ready});
    end
  endtask

  task automatic test_reset_mid_issue();
    ffa_rsp_t rsp;
    int lat;
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 3'd1;
    bus.req_data  = 8'h5A;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if ({ffa_wr[0], ffa_rd[0]} !== 2'b10) begin
      errors++;
      $display("FAIL issue_strobe: wr/rd=%b required 10", {ffa_wr[0], ffa_rd[0]});
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({ffa_wr[0], ffa_rd[0], bus.rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: wr/rd/rsp_valid=%b required 000",
               {ffa_wr[0], ffa_rd[0], bus.rsp_valid});
    end
    @(negedge clk) resetn = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.req_ready, err_cnt} !== {2'b01, 16'd0}) begin
      errors++;
      $display("FAIL reset_drop: valid=%b ready=%b err_cnt=%0d required 0,1,0",
               bus.rsp_valid, bus.req_ready, err_cnt);
    end
    do_txn('{wr: 1'b0, addr: 3'd1, data: 8'h00}, 1'b1, rsp, lat);
    checks++;
    if ({rsp.error, rsp.data, err_cnt} !== {1'b1, 8'h00, 16'd1}) begin
      errors++;
      $display("FAIL reset_read: error=%b data=%h err_cnt=%0d required 1,00,1",
               rsp.error, rsp.data, err_cnt);
    end
  endtask

  task automatic test_saturation();
    ffa_rsp_t rsp;
    int lat;
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      do_txn('{wr: 1'b0, addr: 3'd5, data: 8'h00}, 1'b1, rsp, lat);
      checks++;
      if ({err_cnt, err_cnt_sat} !== {16'(k), 2'((k > 3) ? 3 : k)}) begin
        errors++;
        $display("FAIL sat_count %0d: wide=%0d narrow=%0d required %0d,%0d",
                 k, err_cnt, err_cnt_sat, k, (k > 3) ? 3 : k);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_unwritten_read();
    test_write_read();
    test_all_addresses();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_issue();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ffa_initiator.md
Name: ffa_initiator

Overview:
- Host-side initiator for the 8-entry flip-flop array.
- Accepts one read or write request at a time on a valid/ready request channel and drives the array's din/addr/wr/rd strobes.
- Captures the array's dout/error and returns one response per request on a valid/ready response channel.
- Guarantees wr and rd are never asserted together, and keeps a saturating count of error responses.

Parameters:
DATA_W, 8, data width; must match the array.
ADDR_W, 3, address width; the array has 2**ADDR_W entries.
CNT_W, 16, width of the error counter.

Ports:
clk  in  1  single clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  initiator can accept a request.
req_wr  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  target entry.
req_data  in  DATA_W  write data; ignored for reads.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_wr  out  1  echo of req_wr.
rsp_addr  out  ADDR_W  echo of req_addr.
rsp_data  out  DATA_W  read data; 0 for writes and for errored reads.
rsp_error  out  1  array reported an error.
ffa_wr  out  1  array write strobe, registered.
ffa_rd  out  1  array read strobe, registered.
ffa_addr  out  ADDR_W  array address, registered.
ffa_din  out  DATA_W  array write data, registered.
ffa_dout  in  DATA_W  array read data, registered inside the array.
ffa_error  in  1  array error flag, registered inside the array.
err_cnt  out  CNT_W  saturating count of responses with rsp_error=1.

Behaviour:
- Reset (async assert): FSM goes to IDLE. All outputs go to 0 immediately, including the ffa_wr/ffa_rd strobes; req_ready goes to 1 in IDLE. A request latched before reset is dropped, with no response.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch wr/addr/data into ffa_addr, ffa_din, rsp_wr and rsp_addr.
  - Set ffa_wr=req_wr and ffa_rd=~req_wr, then go to ISSUE.
- ISSUE:
  - req_ready=0; the strobe is high for exactly this one cycle and the array samples it at the closing edge.
  - At that edge: clear ffa_wr and ffa_rd, then go to CAPTURE.
- CAPTURE:
  - The strobes are low; the array's registered dout/error for this op are now valid.
  - At the closing edge: rsp_error<=ffa_error; rsp_data<=(rsp_wr | ffa_error) ? 0 : ffa_dout; rsp_valid<=1.
  - If ffa_error=1 and err_cnt is not at all-ones, increment err_cnt.
  - Go to RESP.
  - This edge is also where the array clears its error because it sees idle strobes; the capture uses the pre-edge value.
- RESP:
  - Hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: clear rsp_valid and go to IDLE. req_ready rises the following cycle; there is no same-cycle bypass.
- Timing:
  - Latency from the req handshake edge to rsp_valid high is 3 cycles.
  - Minimum request spacing is 4 cycles.
- Mutual exclusion: ffa_wr & ffa_rd is never 1 in any cycle. A write is issued as wr only, a read as rd only.
- ffa_addr and ffa_din hold their last values outside ISSUE; the array ignores them when the strobes are low.
- Reads of never-written entries: the array flags an error and leaves dout stale. The initiator returns rsp_error=1 and rsp_data=0.
- Writes: rsp_error is normally 0. It is passed through unchanged if the array reports otherwise.
- err_cnt saturates at 2**CNT_W-1 and is cleared only by reset.
- A req_valid held high through RESP is accepted only in the next IDLE cycle, never in RESP.

Decomposition:
- Shared package ffa_pkg:
  - FFA_DATA_W and FFA_ADDR_W constants.
  - Enum ffa_init_state_e {IDLE, ISSUE, CAPTURE, RESP}.
  - Packed struct ffa_req_t {wr, addr, data}.
  - Packed struct ffa_rsp_t {wr, addr, data, error}.
- No sub-module is needed; a single FSM plus registers.
- The bench instantiates ffa_initiator together with the array model sharing clk/resetn.

Test Plan:
- Write addr 3 data 0xA5, then read addr 3 -> write rsp: wr=1, error=0, data=0. Read rsp: data=0xA5, error=0, rsp_valid 3 cycles after each accept.
- Read addr 6 after reset with no prior write -> rsp_error=1, rsp_data=0, err_cnt=1. Read addr 6 again -> err_cnt=2.
- Write all 8 addresses with 0x10+addr, then read them in reverse order -> data 0x17 down to 0x10, no errors, ffa_wr&ffa_rd never 1 (assertion).
- Backpressure: hold rsp_ready=0 for 5 cycles after a read of addr 3 -> rsp_* stable, req_ready=0 throughout. Release -> req_ready=1 the next cycle.
- Assert resetn=0 mid-ISSUE of a write to addr 1 -> ffa_wr drops immediately, no response is produced. A subsequent read of addr 1 returns error=1, since the array was also reset.
- CNT_W=2: force 5 errored reads -> err_cnt sequence 1, 2, 3, 3, 3.
